// File: rtl/program_load_controller_pkg.sv
// Shared definitions for the UART program loader.
//   loader_state_t      : loader FSM state encoding (BOOT, LOAD, FINISH, RUN)
//   DEFAULT_*           : default timeout and program-memory capacity values
package program_load_controller_pkg;

   typedef enum logic [1:0] {
      StBoot   = 2'd0,
      StLoad   = 2'd1,
      StFinish = 2'd2,
      StRun    = 2'd3
   } loader_state_t;

   localparam int unsigned DEFAULT_START_TIMEOUT = 100000;
   localparam int unsigned DEFAULT_IDLE_TIMEOUT  = 50000;
   localparam int unsigned DEFAULT_MAX_WORDS     = 256;

endpackage

// File: rtl/program_load_controller.sv
// Program loader: assembles big-endian 32-bit words from UART bytes, writes them to
// program memory, then hands the memory address port to the CPU fetch stage.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   io_data_valid/packet      : one-cycle received-byte strobe and its byte
//   cpu_pc_address            : fetch byte address, routed to memory in RUN
//   program_mem_address       : memory byte address (loader address or CPU PC)
//   program_mem_write_enable  : one-cycle write strobe, one cycle after the 4th byte
//   program_mem_write_data    : assembled word for the strobe
//   uart_done                 : registered, high for the whole of RUN
//   load_error                : sticky, load ended with a partial word
//   word_count                : words written so far
module program_load_controller
   import program_load_controller_pkg::*;
#(
   parameter int unsigned START_TIMEOUT = DEFAULT_START_TIMEOUT,
   parameter int unsigned IDLE_TIMEOUT  = DEFAULT_IDLE_TIMEOUT,
   parameter int unsigned MAX_WORDS     = DEFAULT_MAX_WORDS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        io_data_valid,
   input  logic [7:0]  io_data_packet,
   input  logic [31:0] cpu_pc_address,
   output logic [31:0] program_mem_address,
   output logic        program_mem_write_enable,
   output logic [31:0] program_mem_write_data,
   output logic        uart_done,
   output logic        load_error,
   output logic [8:0]  word_count
);

   // One timer serves both the BOOT start timeout and the LOAD idle timeout.
   localparam int unsigned TimerMax = (START_TIMEOUT > IDLE_TIMEOUT) ? START_TIMEOUT
                                                                     : IDLE_TIMEOUT;
   localparam int unsigned TimerW   = $clog2(TimerMax) + 1;
   localparam logic [TimerW-1:0] StartLast = TimerW'(START_TIMEOUT - 1);
   localparam logic [TimerW-1:0] IdleLast  = TimerW'(IDLE_TIMEOUT - 1);
   localparam logic [8:0]        LastWord  = 9'(MAX_WORDS - 1);

   loader_state_t     state_q;
   logic [TimerW-1:0] timer_q;
   logic [1:0]        phase_q;
   logic [31:0]       word_q;
   logic              write_enable_q;
   logic [31:0]       write_data_q;
   logic              uart_done_q;
   logic              load_error_q;
   logic [8:0]        word_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StBoot;
         timer_q        <= '0;
         phase_q        <= 2'd0;
         word_q         <= 32'd0;
         write_enable_q <= 1'b0;
         write_data_q   <= 32'd0;
         uart_done_q    <= 1'b0;
         load_error_q   <= 1'b0;
         word_count_q   <= 9'd0;
      end else begin
         // A strobe lasts one cycle; the count advances as it completes.
         write_enable_q <= 1'b0;
         if (write_enable_q) begin
            word_count_q <= word_count_q + 9'd1;
         end

         unique case (state_q)
            StBoot: begin
               // A byte in the timeout cycle still wins.
               if (io_data_valid) begin
                  state_q <= StLoad;
                  timer_q <= '0;
                  word_q  <= {word_q[23:0], io_data_packet};
                  phase_q <= 2'd1;
               end else if (timer_q == StartLast) begin
                  state_q <= StFinish;
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end

            StLoad: begin
               if (io_data_valid) begin
                  timer_q <= '0;
                  // Shift-in assembly: the first byte ends up in [31:24].
                  word_q  <= {word_q[23:0], io_data_packet};
                  phase_q <= phase_q + 2'd1;
                  if (phase_q == 2'd3) begin
                     write_enable_q <= 1'b1;
                     write_data_q   <= {word_q[23:0], io_data_packet};
                     // Memory full: leave on the edge that raises the last strobe.
                     if (word_count_q == LastWord) begin
                        state_q <= StFinish;
                     end
                  end
               end else if (timer_q == IdleLast) begin
                  state_q <= StFinish;
                  timer_q <= '0;
                  phase_q <= 2'd0;
                  if (phase_q != 2'd0) begin
                     load_error_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end

            StFinish: begin
               state_q     <= StRun;
               uart_done_q <= 1'b1;
            end

            StRun: begin
               // Terminal until reset.
            end
         endcase
      end
   end

   always_comb begin
      program_mem_address = {21'd0, word_count_q, 2'b00};
      if (state_q == StRun) begin
         program_mem_address = cpu_pc_address;
      end
   end

   assign program_mem_write_enable = write_enable_q;
   assign program_mem_write_data   = write_data_q;
   assign uart_done                = uart_done_q;
   assign load_error               = load_error_q;
   assign word_count               = word_count_q;

endmodule
